// File: rtl/mcd_pkg.sv
// ============================================================================
//  Module   : mcd_pkg
//  Desc     : Shared constants and helpers for the multi-channel clock divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mcd_pkg;

   // Default counter / config width and reset-time divider settings
   localparam int                 c_CNT_W    = 26;
   localparam logic [c_CNT_W-1:0] c_DEF_LAST = c_CNT_W'((1 << 26) - 1);
   localparam logic [c_CNT_W-1:0] c_DEF_HIGH = c_CNT_W'(1 << 25);

   // Channel index width; a single-channel build still needs a 1-bit select
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mcd_channel.sv
// ============================================================================
//  Module   : mcd_channel
//  Desc     : One divider channel: counter, active/shadow period and high
//             time, pending flag, registered divided clock and tick.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mcd_channel
   import mcd_pkg::*;
#(
   parameter int               CNT_W    = c_CNT_W,
   parameter logic [CNT_W-1:0] DEF_LAST = CNT_W'(c_DEF_LAST),
   parameter logic [CNT_W-1:0] DEF_HIGH = CNT_W'(c_DEF_HIGH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sync_clr_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_last_i,
   input  logic [CNT_W-1:0] wr_high_i,
   output logic             pend_o,
   output logic             clk_o,
   output logic             tick_o
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_last;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] r_sh_last;
   logic [CNT_W-1:0] r_sh_high;
   logic             r_pend;
   logic             r_clk;
   logic             r_tick;

   logic             w_wrap;
   logic             w_apply;

   // A new config may only take effect at a period boundary: wrap, realign,
   // or while the channel is idle, so no truncated period is ever produced.
   assign w_wrap  = (r_cnt == r_last);
   assign w_apply = sync_clr_i | ~en_i | w_wrap;

   // Active/shadow config: writes go straight to active at a boundary,
   // otherwise they wait in the shadow until the next boundary.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last    <= DEF_LAST;
         r_high    <= DEF_HIGH;
         r_sh_last <= DEF_LAST;
         r_sh_high <= DEF_HIGH;
         r_pend    <= 1'b0;
      end else if (wr_i) begin
         if (w_apply) begin
            r_last <= wr_last_i;
            r_high <= wr_high_i;
            r_pend <= 1'b0;
         end else begin
            r_sh_last <= wr_last_i;
            r_sh_high <= wr_high_i;
            r_pend    <= 1'b1;
         end
      end else if (r_pend && w_apply) begin
         r_last <= r_sh_last;
         r_high <= r_sh_high;
         r_pend <= 1'b0;
      end
   end

   // Counter and output registers; high time is clamped to last upstream,
   // so last-high cannot underflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt  <= '0;
         r_clk  <= 1'b0;
         r_tick <= 1'b0;
      end else if (sync_clr_i || !en_i) begin
         r_cnt  <= '0;
         r_clk  <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_clk  <= (r_cnt > (r_last - r_high));
         r_tick <= w_wrap;
         r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign pend_o = r_pend;
   assign clk_o  = r_clk;
   assign tick_o = r_tick;

endmodule

`default_nettype wire

// File: rtl/multi_clk_divider.sv
// ============================================================================
//  Module   : multi_clk_divider
//  Desc     : NUM_CH independent programmable clock dividers with per-channel
//             enable, one-cycle ticks and a common phase realign.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_clk_divider
   import mcd_pkg::*;
#(
   parameter int               NUM_CH   = 4,
   parameter int               CNT_W    = c_CNT_W,
   parameter logic [CNT_W-1:0] DEF_LAST = CNT_W'(c_DEF_LAST),
   parameter logic [CNT_W-1:0] DEF_HIGH = CNT_W'(c_DEF_HIGH)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_CH-1:0]           en_i,
   input  logic                        sync_clr_i,
   input  logic                        cfg_we_i,
   input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch_i,
   input  logic [CNT_W-1:0]            cfg_last_i,
   input  logic [CNT_W-1:0]            cfg_high_i,
   output logic                        cfg_err_o,
   output logic [NUM_CH-1:0]           cfg_pend_o,
   output logic [NUM_CH-1:0]           clk_o,
   output logic [NUM_CH-1:0]           tick_o
);

   logic [31:0]      w_ch_ext;
   logic             w_bad;
   logic             w_wr_ok;
   logic [CNT_W-1:0] w_high_clamped;
   logic             r_err;

   // Reject a zero period or an out-of-range channel; clamp high to the new last
   assign w_ch_ext       = 32'(cfg_ch_i);
   assign w_bad          = (cfg_last_i == '0) || (w_ch_ext >= 32'(NUM_CH));
   assign w_wr_ok        = cfg_we_i & ~w_bad;
   assign w_high_clamped = (cfg_high_i > cfg_last_i) ? cfg_last_i : cfg_high_i;

   // One-cycle error pulse for a rejected write
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else begin
         r_err <= cfg_we_i & w_bad;
      end
   end

   assign cfg_err_o = r_err;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         mcd_channel #(
            .CNT_W    (CNT_W),
            .DEF_LAST (DEF_LAST),
            .DEF_HIGH (DEF_HIGH)
         ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .en_i       (en_i[g]),
            .sync_clr_i (sync_clr_i),
            .wr_i       (w_wr_ok && (w_ch_ext == 32'(g))),
            .wr_last_i  (cfg_last_i),
            .wr_high_i  (w_high_clamped),
            .pend_o     (cfg_pend_o[g]),
            .clk_o      (clk_o[g]),
            .tick_o     (tick_o[g])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
// ============================================================================
//  Module   : tb_multi_clk_divider
//  Desc     : Directed self-checking bench for multi_clk_divider
//             (NUM_CH=4, CNT_W=8, DEF_LAST=7, DEF_HIGH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_clk_divider;

   logic       clk_i      = 1'b0;
   logic       rst_i      = 1'b1;
   logic [3:0] en_i       = 4'hF;
   logic       sync_clr_i = 1'b0;
   logic       cfg_we_i   = 1'b0;
   logic [1:0] cfg_ch_i   = 2'd0;
   logic [7:0] cfg_last_i = 8'd0;
   logic [7:0] cfg_high_i = 8'd0;
   logic       cfg_err_o;
   logic [3:0] cfg_pend_o;
   logic [3:0] clk_o;
   logic [3:0] tick_o;

   int n_checks = 0;
   int n_err    = 0;

   multi_clk_divider #(
      .NUM_CH   (4),
      .CNT_W    (8),
      .DEF_LAST (8'd7),
      .DEF_HIGH (8'd4)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .sync_clr_i (sync_clr_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_ch_i   (cfg_ch_i),
      .cfg_last_i (cfg_last_i),
      .cfg_high_i (cfg_high_i),
      .cfg_err_o  (cfg_err_o),
      .cfg_pend_o (cfg_pend_o),
      .clk_o      (clk_o),
      .tick_o     (tick_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ck/tk hold one expected nibble per step, step 0 in the low nibble
   task automatic run_steps(input string tag, input int n, input logic [31:0] ck,
                            input logic [31:0] tk, input logic [3:0] mask);
      for (int i = 0; i < n; i++) begin
         step();
         check({tag, "_clk"},  32'(clk_o & mask),  32'(ck[i*4 +: 4] & mask));
         check({tag, "_tick"}, 32'(tick_o & mask), 32'(tk[i*4 +: 4] & mask));
      end
   endtask

   task automatic write(input logic [1:0] ch, input logic [7:0] last, input logic [7:0] high);
      cfg_we_i   = 1'b1;
      cfg_ch_i   = ch;
      cfg_last_i = last;
      cfg_high_i = high;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values
      step();
      step();
      check("rst_clk",  32'(clk_o),      32'h0);
      check("rst_tick", 32'(tick_o),     32'h0);
      check("rst_pend", 32'(cfg_pend_o), 32'h0);
      check("rst_err",  32'(cfg_err_o),  32'h0);
      rst_i = 1'b0;

      // ---- defaults: 4 low / 4 high, tick every 8 (edges 1..16)
      run_steps("def_a", 8, 32'hFFFF_0000, 32'hF000_0000, 4'hF);
      run_steps("def_b", 8, 32'hFFFF_0000, 32'hF000_0000, 4'hF);

      // ---- ch1 last=3 high=2 written mid-period (edge 17, cnt=0)
      write(2'd1, 8'd3, 8'd2);
      step();
      cfg_we_i = 1'b0;
      check("ch1_pend_set", 32'(cfg_pend_o), 32'h2);
      check("ch1_wr_clk",   32'(clk_o),      32'h0);
      run_steps("ch1_old", 6, 32'h00FF_F000, 32'h0, 4'hF);
      check("ch1_pend_hold", 32'(cfg_pend_o), 32'h2);
      step();  // edge 24: wrap, shadow applied
      check("ch1_pend_clr", 32'(cfg_pend_o), 32'h0);
      check("ch1_wrap_tick", 32'(tick_o),    32'hF);
      run_steps("ch1_new", 8, 32'hFFDD_2200, 32'hF000_2000, 4'hF);

      // ---- rejected write: last=0 on ch2
      write(2'd2, 8'd0, 8'd1);
      step();
      cfg_we_i = 1'b0;
      check("err_pulse", 32'(cfg_err_o),  32'h1);
      check("err_pend",  32'(cfg_pend_o), 32'h0);
      step();
      check("err_drop",  32'(cfg_err_o),  32'h0);

      // ---- ch0 high=20 clamps to last=7 (edge 35, cnt=2)
      write(2'd0, 8'd7, 8'd20);
      step();
      cfg_we_i = 1'b0;
      check("clamp_pend", 32'(cfg_pend_o), 32'h1);
      for (int i = 0; i < 4; i++) step();
      step();  // edge 40: wrap
      check("clamp_pend_clr", 32'(cfg_pend_o), 32'h0);
      run_steps("clamp", 8, 32'hFFDD_3310, 32'hF000_2000, 4'hF);

      // ---- ch3 disabled 5 cycles, then re-enabled
      en_i = 4'b0111;
      run_steps("en_low", 5, 32'h0, 32'h0, 4'h8);
      en_i = 4'hF;
      run_steps("en_rise", 8, 32'h8888_0000, 32'h8000_0000, 4'h8);

      // ---- sync_clr with a pending write on ch0
      write(2'd0, 8'd3, 8'd1);
      step();
      cfg_we_i = 1'b0;
      check("clr_pend_set", 32'(cfg_pend_o), 32'h1);
      sync_clr_i = 1'b1;
      step();
      sync_clr_i = 1'b0;
      check("clr_clk",  32'(clk_o),      32'h0);
      check("clr_tick", 32'(tick_o),     32'h0);
      check("clr_pend", 32'(cfg_pend_o), 32'h0);
      run_steps("realign", 8, 32'hFECC_3200, 32'hF000_3000, 4'hF);

      // ---- write landing exactly on ch2's wrap edge (edge 79)
      for (int i = 0; i < 7; i++) step();
      write(2'd2, 8'd1, 8'd1);
      step();
      cfg_we_i = 1'b0;
      check("wrapwr_pend", 32'(cfg_pend_o), 32'h0);
      run_steps("wrapwr", 4, 32'h0000_4040, 32'h0000_4040, 4'h4);

      // ---- async reset in ch3's high phase with a pending write
      write(2'd3, 8'd5, 8'd2);
      step();
      cfg_we_i = 1'b0;
      check("pre_rst_clk3", 32'(clk_o[3]),   32'h1);
      check("pre_rst_pend", 32'(cfg_pend_o), 32'h8);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_clk",  32'(clk_o),      32'h0);
      check("arst_tick", 32'(tick_o),     32'h0);
      check("arst_pend", 32'(cfg_pend_o), 32'h0);
      step();
      step();
      rst_i = 1'b0;
      run_steps("post_rst_a", 8, 32'hFFFF_0000, 32'hF000_0000, 4'hF);
      run_steps("post_rst_b", 8, 32'hFFFF_0000, 32'hF000_0000, 4'hF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
